// File: rtl/shp_sched_pkg.sv
// Shared types and constants for the slice header parser scheduler.
package shp_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_START   = 3'd1,
      S_WAIT    = 3'd2,
      S_RELEASE = 3'd3,
      S_SETTLE  = 3'd4,
      S_FLUSH   = 3'd5
   } sched_state_t;

   // Completion status returned to the channel with ack.
   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_PERR = 2'b01;
   localparam logic [1:0] ST_TMO  = 2'b10;

   // Parsed header field widths.
   localparam int W_SLICE_TYPE = 2;
   localparam int W_REF_IDX    = 3;
   localparam int W_QP_DELTA   = 6;
   localparam int W_BIT_POS    = 12;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or after rr_ptr,
// wrapping modulo NUM_CH. The pointer register lives in the caller.
module rr_arbiter #(
   parameter  int NUM_CH = 4,
   localparam int IDX_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  rr_ptr,
   output logic [IDX_W-1:0]  grant_idx,
   output logic              any_req
);

   // Scan channels starting at the pointer; the first hit wins.
   always_comb begin
      int j;
      j         = 0;
      grant_idx = '0;
      any_req   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= NUM_CH) j = j - NUM_CH;
         if (!any_req && req[IDX_W'(j)]) begin
            any_req   = 1'b1;
            grant_idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/slice_header_sched.sv
// Sequencer and round-robin arbiter sharing one slice header parser between
// NUM_CH channels. Define SHP_WATCHDOG_EN to add the WAIT watchdog, which
// flushes a parser that never completes and returns timeout status.
// Handshake: req is a level held by the channel until its one-cycle ack pulse;
// done_* and done_status are valid in the ack cycle. Toward the parser,
// hp_start strobes once to start and once to release from DONE/ERROR.
module slice_header_sched
   import shp_sched_pkg::*;
#(
   parameter  int NUM_CH      = 4,
   parameter  int TIMEOUT_CYC = 32,
   localparam int SEL_W       = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CH-1:0]       req,
   output logic [NUM_CH-1:0]       ack,
   output logic [1:0]              done_status,
   output logic [W_SLICE_TYPE-1:0] done_slice_type,
   output logic [W_REF_IDX-1:0]    done_ref_l0,
   output logic [W_REF_IDX-1:0]    done_ref_l1,
   output logic [W_QP_DELTA-1:0]   done_qp_delta,
   output logic [W_BIT_POS-1:0]    done_bit_pos,
   output logic [SEL_W-1:0]        hp_sel,
   output logic                    hp_start,
   output logic                    hp_flush,
   input  logic                    hp_valid,
   input  logic                    hp_error,
   input  logic [W_SLICE_TYPE-1:0] hp_slice_type,
   input  logic [W_REF_IDX-1:0]    hp_ref_l0,
   input  logic [W_REF_IDX-1:0]    hp_ref_l1,
   input  logic [W_QP_DELTA-1:0]   hp_qp_delta,
   input  logic [W_BIT_POS-1:0]    hp_bit_pos,
   output sched_state_t            state_o
);

   sched_state_t            state_q, state_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic [SEL_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [1:0]              status_q, status_d;
   logic [W_SLICE_TYPE-1:0] type_q, type_d;
   logic [W_REF_IDX-1:0]    ref0_q, ref0_d;
   logic [W_REF_IDX-1:0]    ref1_q, ref1_d;
   logic [W_QP_DELTA-1:0]   qp_q, qp_d;
   logic [W_BIT_POS-1:0]    bp_q, bp_d;
   logic [SEL_W-1:0]        grant_idx;
   logic                    any_req;
   logic [NUM_CH-1:0]       sel_onehot;

`ifdef SHP_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT_CYC == 0);
`endif

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req       (req),
      .rr_ptr    (rr_ptr_q),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   // Next-state, grant and capture logic.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      rr_ptr_d = rr_ptr_q;
      status_d = status_q;
      type_d   = type_q;
      ref0_d   = ref0_q;
      ref1_d   = ref1_q;
      qp_d     = qp_q;
      bp_d     = bp_q;
`ifdef SHP_WATCHDOG_EN
      wd_cnt_d = wd_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               sel_d    = grant_idx;
               rr_ptr_d = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
               state_d  = S_START;
            end
         end
         S_START: begin
`ifdef SHP_WATCHDOG_EN
            wd_cnt_d = '0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Error beats valid; any completion flag beats the watchdog.
            if (hp_error) begin
               status_d = ST_PERR;
               state_d  = S_RELEASE;
            end else if (hp_valid) begin
               status_d = ST_OK;
               type_d   = hp_slice_type;
               ref0_d   = hp_ref_l0;
               ref1_d   = hp_ref_l1;
               qp_d     = hp_qp_delta;
               bp_d     = hp_bit_pos;
               state_d  = S_RELEASE;
            end
`ifdef SHP_WATCHDOG_EN
            // The counter holds completed WAIT cycles, so this is the
            // TIMEOUT_CYC-th cycle spent waiting.
            else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
               status_d = ST_TMO;
               state_d  = S_FLUSH;
            end else begin
               wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
`endif
         end
         S_RELEASE: state_d = S_SETTLE;
         S_FLUSH:   state_d = S_SETTLE;
         S_SETTLE:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // State and captured-field registers; reset aborts any transaction silently.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         sel_q    <= '0;
         rr_ptr_q <= '0;
         status_q <= ST_OK;
         type_q   <= '0;
         ref0_q   <= '0;
         ref1_q   <= '0;
         qp_q     <= '0;
         bp_q     <= '0;
`ifdef SHP_WATCHDOG_EN
         wd_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         rr_ptr_q <= rr_ptr_d;
         status_q <= status_d;
         type_q   <= type_d;
         ref0_q   <= ref0_d;
         ref1_q   <= ref1_d;
         qp_q     <= qp_d;
         bp_q     <= bp_d;
`ifdef SHP_WATCHDOG_EN
         wd_cnt_q <= wd_cnt_d;
`endif
      end
   end

   assign sel_onehot      = NUM_CH'(1) << sel_q;
   assign ack             = (state_q == S_RELEASE || state_q == S_FLUSH) ? sel_onehot : '0;
   assign hp_start        = (state_q == S_START) || (state_q == S_RELEASE);
`ifdef SHP_WATCHDOG_EN
   assign hp_flush        = (state_q == S_FLUSH);
`else
   assign hp_flush        = 1'b0;
`endif
   assign hp_sel          = sel_q;
   assign done_status     = status_q;
   assign done_slice_type = type_q;
   assign done_ref_l0     = ref0_q;
   assign done_ref_l1     = ref1_q;
   assign done_qp_delta   = qp_q;
   assign done_bit_pos    = bp_q;
   assign state_o         = state_q;

endmodule
